// File: rtl/fft_mac_scheduler.sv
// fft_mac_scheduler: sequences the multiplier and accumulator arrays for one FFT-domain output tile.
// Ports: clk_i/reset_i (sync active-high); start_i + cfg_num_channels_i begin a tile, busy_o outside IDLE;
// in_valid_i/in_ready_o take one channel tile per handshake and fire mult_next_o in the same cycle;
// mult_next_out_i retires products onto acc_in_valid_o/acc_first_o/acc_last_o; acc_output_valid_i
// finishes the sum; out_valid_o/out_ready_i hand the tile on with tile_done_o; err_o is sticky.
module fft_mac_scheduler #(
  parameter int CH_W    = 10,
  parameter int TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [CH_W-1:0] cfg_num_channels_i,
  output logic            busy_o,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            mult_next_o,
  input  logic            mult_next_out_i,
  output logic            acc_in_valid_o,
  output logic            acc_first_o,
  output logic            acc_last_o,
  input  logic            acc_output_valid_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            tile_done_o,
  output logic            err_o
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_ACC, OUTPUT} state_e;
  state_e state_q, state_d;
  logic [CH_W-1:0] n_q, n_d, issued_q, issued_d, retired_q, retired_d;
  logic [TW-1:0] timer_q, timer_d;
  logic err_q, err_d;
  logic start_acc, hs, ret_ok, ret_bad, timeout;
  assign start_acc = start_i && state_q == IDLE;
  assign hs        = in_valid_i && state_q == ISSUE;
  // a product only counts while channels are in flight and the sum is not yet complete
  assign ret_ok    = mult_next_out_i && (state_q == ISSUE || state_q == DRAIN) && retired_q != n_q;
  assign ret_bad   = mult_next_out_i && !ret_ok;
  assign timeout   = timer_q == TW'(TIMEOUT);
  assign busy_o         = state_q != IDLE;
  assign in_ready_o     = state_q == ISSUE;
  assign mult_next_o    = hs;
  assign acc_in_valid_o = mult_next_out_i;
  assign acc_first_o    = ret_ok && retired_q == '0;
  assign acc_last_o     = ret_ok && retired_q == n_q - 1'b1;
  assign out_valid_o    = state_q == OUTPUT;
  assign tile_done_o    = out_valid_o && out_ready_i;
  assign err_o          = err_q;
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    issued_d  = hs ? issued_q + 1'b1 : issued_q;
    retired_d = ret_ok ? retired_q + 1'b1 : retired_q;
    timer_d   = (state_q == DRAIN || state_q == WAIT_ACC) ? timer_q + 1'b1 : '0;
    err_d     = (start_acc ? 1'b0 : err_q) | ret_bad |
                (acc_output_valid_i && (state_q == ISSUE || state_q == DRAIN));
    case (state_q)
      IDLE: if (start_i) begin
        state_d   = ISSUE;
        n_d       = cfg_num_channels_i == '0 ? CH_W'(1) : cfg_num_channels_i;
        issued_d  = '0;
        retired_d = '0;
      end
      ISSUE: if (hs && issued_q == n_q - 1'b1) state_d = DRAIN;
      DRAIN: begin
        if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (retired_d == n_q) begin
          state_d = WAIT_ACC;
          timer_d = '0;
        end
      end
      WAIT_ACC: begin
        if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (acc_output_valid_i) state_d = OUTPUT;
      end
      OUTPUT: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      n_q       <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_fft_mac_scheduler.sv
// tb_fft_mac_scheduler: randomized scoreboard bench for fft_mac_scheduler.
module tb_fft_mac_scheduler;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, arr_out = 0, man_pulse = 0, acc_ov = 0, out_ready = 0;
  logic [9:0] cfg = 0;
  logic mno, busy, in_ready, mult_next, acc_in_valid, acc_first, acc_last, out_valid, tile_done, err;
  logic [15:0] hist = 0;
  logic [2:0] exp_acc[$];
  int exp_done[$];
  int n_chk = 0, n_fail = 0, lat = 4, mn_cnt = 0;
  bit kill = 0;
  assign mno = arr_out | man_pulse;
  always #5 clk = ~clk;
  fft_mac_scheduler #(.CH_W(10), .TIMEOUT(64)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .cfg_num_channels_i(cfg), .busy_o(busy),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .mult_next_o(mult_next), .mult_next_out_i(mno),
    .acc_in_valid_o(acc_in_valid), .acc_first_o(acc_first), .acc_last_o(acc_last),
    .acc_output_valid_i(acc_ov), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .tile_done_o(tile_done), .err_o(err)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic bad(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // multiplier array stand-in: echoes each mult_next lat cycles later
  initial forever begin
    logic cur;
    @(negedge clk);
    cur = mult_next;
    @(posedge clk);
    #1;
    hist = kill ? '0 : {hist[14:0], cur};
    arr_out = !kill && hist[lat-1];
  end
  // monitor: pops expectations whenever the DUT presents an accumulator beat or a finished tile
  initial forever begin
    logic [2:0] e;
    @(negedge clk);
    if (!busy && start && !reset) mn_cnt = 0;
    if (mult_next) mn_cnt++;
    if (acc_in_valid) begin
      if (exp_acc.size() == 0) bad("acc_unexpected");
      else begin
        e = exp_acc.pop_front();
        if (e[2]) chk("acc_first_last", {30'd0, acc_first, acc_last}, {30'd0, e[1:0]});
      end
    end
    if (tile_done) begin
      if (exp_done.size() == 0) bad("tile_done_unexpected");
      else chk("tile_mult_next_count", mn_cnt, exp_done.pop_front());
    end
  end
  task automatic run_tile(int c, int gap, int l, int bp, bit do_acc);
    int nn, iss, b;
    bit hs;
    nn = (c == 0) ? 1 : c;
    iss = 0;
    b = 0;
    lat = l;
    for (int k = 0; k < nn; k++) exp_acc.push_back({1'b1, k == 0, k == nn - 1});
    if (do_acc) exp_done.push_back(nn);
    start = 1;
    cfg = 10'(c);
    cyc(1);
    start = 0;
    cfg = 10'($urandom);
    chk("busy_after_start", busy, 1);
    chk("err_clear_after_start", err, 0);
    while (iss < nn && b < 2000) begin
      in_valid = ($urandom_range(99) >= gap);
      @(negedge clk);
      hs = in_valid && in_ready;
      chk("mult_next_vs_handshake", mult_next, hs);
      @(posedge clk);
      #1;
      if (hs) iss++;
      b++;
    end
    in_valid = 0;
    chk("issue_complete", iss, nn);
    if (gap == 0) chk("issue_cycles", b, nn);
    cyc(l + 3 + $urandom_range(3));
    chk("busy_draining", busy, 1);
    chk("in_ready_draining", in_ready, 0);
    if (!do_acc) return;
    acc_ov = 1;
    cyc(1);
    acc_ov = 0;
    for (int i = 0; i < bp; i++) begin
      start = 1;
      cfg = 10'($urandom);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_tile_done", tile_done, 0);
      @(posedge clk);
      #1;
    end
    start = 0;
    out_ready = 1;
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("tile_done", tile_done, 1);
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("busy_after_done", busy, 0);
    chk("out_valid_after_done", out_valid, 0);
    chk("err_after_tile", err, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    cyc(3);
    @(negedge clk);
    chk("reset_outputs", {busy, in_ready, mult_next, acc_in_valid, acc_first, acc_last, out_valid, tile_done, err}, 0);
    @(posedge clk);
    #1;
    reset = 0;
    cyc(1);
    run_tile(4, 0, 6, 0, 1);
    run_tile(0, 0, 3, 0, 1);
    run_tile(1, 0, 5, 0, 1);
    run_tile(3, 50, 4, 0, 1);
    run_tile(3, 0, 2, 0, 1);
    run_tile(2, 0, 3, 10, 1);
    man_pulse = 1;
    exp_acc.push_back(3'b000);
    cyc(1);
    man_pulse = 0;
    @(negedge clk);
    chk("err_mult_next_out_idle", err, 1);
    @(posedge clk);
    #1;
    run_tile(3, 0, 4, 0, 0);
    cyc(80);
    chk("timeout_busy", busy, 0);
    chk("timeout_err", err, 1);
    run_tile(2, 20, 3, 1, 1);
    lat = 6;
    start = 1;
    cfg = 5;
    cyc(1);
    start = 0;
    in_valid = 1;
    cyc(2);
    in_valid = 0;
    reset = 1;
    kill = 1;
    cyc(1);
    @(negedge clk);
    chk("midtile_reset_outputs", {busy, in_ready, mult_next, acc_in_valid, acc_first, acc_last, out_valid, tile_done, err}, 0);
    @(posedge clk);
    #1;
    reset = 0;
    kill = 0;
    cyc(1);
    run_tile(2, 0, 4, 0, 1);
    repeat (20) run_tile($urandom_range(0, 12), $urandom_range(0, 60), $urandom_range(1, 8), $urandom_range(0, 3), 1);
    run_tile(40, 10, 8, 2, 1);
    cyc(12);
    chk("acc_queue_drained", exp_acc.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
